// File: rtl/phys_free_list_if.sv
// ----------------------------------------------------------------------------
// phys_free_list_if
//   Bundles the rename-side allocation handshake and the ROB-side free/commit/
//   flush signals of the physical register free list.
//
//   Handshake: alloc_valid is raised by the free list whenever a tag is
//   available and alloc_tag is then meaningful. An allocation happens on a
//   rising clk edge where alloc_req && alloc_valid (and no flush) are both
//   high. alloc_req without alloc_valid is ignored and the requester must
//   stall. free_req/commit_req/flush are single-cycle strobes with no
//   back-pressure.
//
//   master : rename/ROB side (drives requests, observes status)
//   slave  : free list side
// ----------------------------------------------------------------------------
interface phys_free_list_if #(
    parameter int PTAG_WIDTH = 6,
    parameter int CNT_WIDTH  = 6
);
    logic                  alloc_req;
    logic                  alloc_valid;
    logic [PTAG_WIDTH-1:0] alloc_tag;
    logic                  free_req;
    logic [PTAG_WIDTH-1:0] free_tag;
    logic                  commit_req;
    logic                  flush;
    logic [CNT_WIDTH-1:0]  free_count;
    logic                  overflow_err;

    modport master (
        output alloc_req, free_req, free_tag, commit_req, flush,
        input  alloc_valid, alloc_tag, free_count, overflow_err
    );

    modport slave (
        input  alloc_req, free_req, free_tag, commit_req, flush,
        output alloc_valid, alloc_tag, free_count, overflow_err
    );
endinterface

// File: rtl/phys_free_list.sv
// ----------------------------------------------------------------------------
// phys_free_list
//   Circular FIFO of unallocated physical register tags for the rename stage.
//   Tags NUM_AREGS..NUM_PREGS-1 start in the list; tags returned by the ROB on
//   commit are appended at the tail and handed out again from the head.
//
//   Optional feature macro: FREELIST_FLUSH_EN
//     defined   : a committed (retire) head/count pair is kept so that flush
//                 rewinds the speculative head to the last committed point.
//     undefined : commit_req and flush are ignored; recovery is drain+reset.
//
//   Ports:
//     clk  - clock, all state updates on posedge
//     rst  - asynchronous active-low reset
//     bus  - phys_free_list_if.slave
//              alloc_req/alloc_valid/alloc_tag  rename allocation (show-ahead)
//              free_req/free_tag                tag returned by ROB
//              commit_req                       allocation retired
//              flush                            mispredict recovery
//              free_count                       speculative free tag count
//              overflow_err                     sticky free-while-full flag
// ----------------------------------------------------------------------------
module phys_free_list #(
    parameter int NUM_PREGS  = 64,
    parameter int NUM_AREGS  = 32,
    parameter int DEPTH      = NUM_PREGS - NUM_AREGS,   // must be a power of two
    parameter int PTAG_WIDTH = $clog2(NUM_PREGS)
) (
    input  logic            clk,
    input  logic            rst,
    phys_free_list_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTAG_WIDTH-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  alloc_fire;
    logic                  free_fire;
    logic                  list_full;

`ifdef FREELIST_FLUSH_EN
    logic [PTR_W-1:0]      rhead_q, rhead_d;
    logic [CNT_W-1:0]      rcount_q, rcount_d;
`else
    logic                  unused_flush_inputs;
    assign unused_flush_inputs = bus.flush ^ bus.commit_req;
`endif

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        overflow_d = overflow_q;
`ifdef FREELIST_FLUSH_EN
        rhead_d    = rhead_q;
        rcount_d   = rcount_q;
        alloc_fire = bus.alloc_req && (count_q != '0) && !bus.flush;
        // Slots holding allocated-but-uncommitted tags are not reusable, so
        // capacity is judged against the committed occupancy.
        list_full  = (rcount_q == CNT_W'(DEPTH));
`else
        alloc_fire = bus.alloc_req && (count_q != '0);
        list_full  = (count_q == CNT_W'(DEPTH));
`endif
        free_fire = bus.free_req && !list_full;
        if (bus.free_req && list_full) begin
            overflow_d = 1'b1;
        end
        if (alloc_fire) begin
            head_d = head_q + PTR_W'(1);
        end
        if (free_fire) begin
            tail_d = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(free_fire) - CNT_W'(alloc_fire);
`ifdef FREELIST_FLUSH_EN
        if (bus.commit_req) begin
            rhead_d = rhead_q + PTR_W'(1);
        end
        rcount_d = rcount_q + CNT_W'(free_fire) - CNT_W'(bus.commit_req);
        // Flush rewinds to the committed point including this cycle's
        // commit and free.
        if (bus.flush) begin
            head_d  = rhead_d;
            count_d = rcount_d;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= PTAG_WIDTH'(NUM_AREGS + i);
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= CNT_W'(DEPTH);
            overflow_q <= 1'b0;
`ifdef FREELIST_FLUSH_EN
            rhead_q    <= '0;
            rcount_q   <= CNT_W'(DEPTH);
`endif
        end else begin
            if (free_fire) begin
                entry_q[tail_q] <= bus.free_tag;
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef FREELIST_FLUSH_EN
            rhead_q    <= rhead_d;
            rcount_q   <= rcount_d;
`endif
        end
    end

    // Show-ahead: the head entry is visible before the request arrives.
    assign bus.alloc_valid  = (count_q != '0);
    assign bus.alloc_tag    = entry_q[head_q];
    assign bus.free_count   = count_q;
    assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_phys_free_list.sv
// ----------------------------------------------------------------------------
// tb_phys_free_list
//   Self-checking bench for phys_free_list: reset check, a vector table,
//   hand-written multi-cycle sequences and a randomized run against a
//   queue-based reference model of the free list.
// ----------------------------------------------------------------------------
module tb_phys_free_list;
    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int DEPTH     = 32;
    localparam int PTAG_W    = 6;
    localparam int CNT_W     = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    phys_free_list_if #(.PTAG_WIDTH(PTAG_W), .CNT_WIDTH(CNT_W)) bus ();

    phys_free_list #(
        .NUM_PREGS(NUM_PREGS),
        .NUM_AREGS(NUM_AREGS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- scoreboard / model ----------------
    logic [PTAG_W-1:0] exp_q[$];     // expected allocation order for drain
    logic [PTAG_W-1:0] free_q[$];    // model: tags from committed head to tail
    int                n_unc;        // model: allocated but not committed
    bit                m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        for (int i = 0; i < DEPTH; i++) free_q.push_back(PTAG_W'(NUM_AREGS + i));
        n_unc = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input bit a, input bit f, input logic [PTAG_W-1:0] t,
                              input bit c, input bit fl);
        int  spec;
        bit  a_fire;
        bit  f_fire;
        spec = free_q.size() - n_unc;
`ifdef FREELIST_FLUSH_EN
        a_fire = a && (spec > 0) && !fl;
`else
        a_fire = a && (spec > 0);
`endif
        f_fire = f && (free_q.size() < DEPTH);
        if (f && !f_fire) m_ovf = 1'b1;
        if (a_fire) begin
`ifdef FREELIST_FLUSH_EN
            n_unc++;
`else
            void'(free_q.pop_front());
`endif
        end
        if (f_fire) free_q.push_back(t);
`ifdef FREELIST_FLUSH_EN
        if (c) begin
            void'(free_q.pop_front());
            n_unc--;
        end
        if (fl) n_unc = 0;
`else
        if (c || fl) begin end
`endif
    endtask

    task automatic model_check(input string name);
        int cnt;
        cnt = free_q.size() - n_unc;
        check({name, ".valid"}, 32'(bus.alloc_valid), 32'(cnt != 0));
        check({name, ".count"}, 32'(bus.free_count), 32'(cnt));
        check({name, ".ovf"}, 32'(bus.overflow_err), 32'(m_ovf));
        if (cnt != 0) check({name, ".tag"}, 32'(bus.alloc_tag), 32'(free_q[n_unc]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit a, input bit f, input logic [PTAG_W-1:0] t,
                         input bit c, input bit fl);
        bus.alloc_req  = a;
        bus.free_req   = f;
        bus.free_tag   = t;
        bus.commit_req = c;
        bus.flush      = fl;
    endtask

    // Apply inputs for one cycle, step the model, land #1 after the edge.
    task automatic cycle(input bit a, input bit f, input logic [PTAG_W-1:0] t,
                         input bit c, input bit fl);
        drive(a, f, t, c, fl);
        @(posedge clk);
        model_step(a, f, t, c, fl);
        #1;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic              a;
        logic              f;
        logic [PTAG_W-1:0] t;
        logic              ev;
        logic [PTAG_W-1:0] etag;
        logic [CNT_W-1:0]  ecnt;
        logic              eovf;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // outputs expected in the cycle the row's inputs are applied
        vecs[0] = '{1'b1, 1'b0, 6'd0,  1'b1, 6'd32, 6'd32, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 6'd0,  1'b1, 6'd33, 6'd31, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 6'd0,  1'b1, 6'd34, 6'd30, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 6'd7,  1'b1, 6'd35, 6'd29, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 6'd0,  1'b1, 6'd36, 6'd29, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 6'd12, 1'b1, 6'd36, 6'd29, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 6'd0,  1'b1, 6'd36, 6'd30, 1'b0};

        // ---- reset check ----
        do_reset();
        check("reset.valid", 32'(bus.alloc_valid), 32'd1);
        check("reset.tag", 32'(bus.alloc_tag), 32'd32);
        check("reset.count", 32'(bus.free_count), 32'd32);
        check("reset.ovf", 32'(bus.overflow_err), 32'd0);

        // ---- table ----
        for (int i = 0; i < 7; i++) begin
            check($sformatf("vec%0d.valid", i), 32'(bus.alloc_valid), 32'(vecs[i].ev));
            if (vecs[i].ev) check($sformatf("vec%0d.tag", i), 32'(bus.alloc_tag), 32'(vecs[i].etag));
            check($sformatf("vec%0d.count", i), 32'(bus.free_count), 32'(vecs[i].ecnt));
            check($sformatf("vec%0d.ovf", i), 32'(bus.overflow_err), 32'(vecs[i].eovf));
            cycle(vecs[i].a, vecs[i].f, vecs[i].t, 1'b0, 1'b0);
        end

        // ---- drain + recycle ----
        do_reset();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(PTAG_W'(NUM_AREGS + i));
        for (int i = 0; i < DEPTH; i++) begin
            check("drain.valid", 32'(bus.alloc_valid), 32'd1);
            check("drain.tag", 32'(bus.alloc_tag), 32'(exp_q.pop_front()));
            cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        end
        check("drain.empty_valid", 32'(bus.alloc_valid), 32'd0);
        check("drain.empty_count", 32'(bus.free_count), 32'd0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);   // 33rd request: no-op
        check("drain.noop_count", 32'(bus.free_count), 32'd0);
        // cycle N: free 5 with alloc held; no bypass
        check("recycle.n_valid", 32'(bus.alloc_valid), 32'd0);
        cycle(1'b1, 1'b1, 6'd5, 1'b0, 1'b0);
        check("recycle.n1_valid", 32'(bus.alloc_valid), 32'd1);
        check("recycle.n1_tag", 32'(bus.alloc_tag), 32'd5);
        check("recycle.n1_count", 32'(bus.free_count), 32'd1);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("recycle.after_count", 32'(bus.free_count), 32'd0);
        check("recycle.after_valid", 32'(bus.alloc_valid), 32'd0);

        // ---- wrap and simultaneous ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check("wrap.first_tag", 32'(bus.alloc_tag), 32'(NUM_AREGS + i));
            cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b1, 6'd7, 1'b0, 1'b0);
        check("wrap.simul_count", 32'(bus.free_count), 32'd29);
        for (int i = 0; i < 28; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("wrap.recycled_tag", 32'(bus.alloc_tag), 32'd7);
        check("wrap.recycled_count", 32'(bus.free_count), 32'd1);

        // ---- overflow ----
        do_reset();
        cycle(1'b0, 1'b1, 6'd9, 1'b0, 1'b0);
        check("ovf.count", 32'(bus.free_count), 32'd32);
        check("ovf.flag", 32'(bus.overflow_err), 32'd1);
        check("ovf.tag", 32'(bus.alloc_tag), 32'd32);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("ovf.sticky", 32'(bus.overflow_err), 32'd1);
        check("ovf.next_tag", 32'(bus.alloc_tag), 32'd33);

`ifdef FREELIST_FLUSH_EN
        // ---- flush ----
        do_reset();
        repeat (4) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("flush.pre_count", 32'(bus.free_count), 32'd28);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("flush.tag", 32'(bus.alloc_tag), 32'd33);
        check("flush.count", 32'(bus.free_count), 32'd31);
`endif

        // ---- randomized run against the model ----
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit a, f, c, fl;
            logic [PTAG_W-1:0] t;
            model_check("rand");
            a  = ($urandom_range(0, 99) < 55);
            f  = ($urandom_range(0, 99) < 45);
            t  = PTAG_W'($urandom_range(0, NUM_PREGS - 1));
            fl = ($urandom_range(0, 19) == 0);
`ifdef FREELIST_FLUSH_EN
            c  = (n_unc > 0) && ($urandom_range(0, 99) < 40);
`else
            c  = ($urandom_range(0, 99) < 40);
`endif
            cycle(a, f, t, c, fl);
        end
        model_check("rand_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/phys_free_list.md
Name: phys_free_list

Overview:
- Circular FIFO of unallocated physical register tags for the rename stage.
- Sits directly upstream of the RAT/ARF and supplies the tag it writes into paddr[rd] on new_entry.
- The ROB returns the superseded physical tag on commit, and that tag is recycled here.
- A retire-side pointer allows the speculative allocation pointer to be restored on a pipeline flush.

Parameters:
- NUM_PREGS, 64, total physical registers.
- NUM_AREGS, 32, architectural registers; tags 0..NUM_AREGS-1 are mapped at reset and never start in the list.
- DEPTH, NUM_PREGS-NUM_AREGS (32), free list entries.
- PTAG_WIDTH, $clog2(NUM_PREGS) (6), tag width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- alloc_req  in  1  rename wants a tag; asserted only for rd != x0.
- alloc_valid  out  1  a free tag is available (free_count != 0).
- alloc_tag  out  PTAG_WIDTH  tag at the head of the list (show-ahead).
- free_req  in  1  ROB commit returns a tag.
- free_tag  in  PTAG_WIDTH  tag being returned.
- commit_req  in  1  ROB retired an instruction that had allocated a tag.
- flush  in  1  mispredict/exception recovery.
- free_count  out  $clog2(DEPTH+1)  speculative number of free tags.
- overflow_err  out  1  sticky; a free was attempted while the list was full.

Behaviour:
- State:
  - entry[DEPTH] of PTAG_WIDTH.
  - head: speculative read pointer.
  - retire_head: committed read pointer.
  - tail: write pointer.
  - count: speculative occupancy.
  - retire_count: tail-to-retire_head occupancy.
  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0; DEPTH must be a power of two.
- Reset (rst low, asynchronous):
  - entry[i] = NUM_AREGS+i.
  - head = retire_head = tail = 0.
  - count = retire_count = DEPTH.
  - overflow_err = 0.
  - Outputs therefore read alloc_valid=1, alloc_tag=NUM_AREGS, free_count=DEPTH.
- Allocation:
  - alloc_tag = entry[head] combinationally; zero-latency show-ahead.
  - Allocation fires when alloc_req && alloc_valid && !flush; head advances by 1 at the next edge.
  - alloc_req while alloc_valid=0 is a no-op; rename must stall.
  - When count=0, alloc_tag is don't-care.
- Free:
  - free_req writes entry[tail] <= free_tag and advances tail.
  - count and retire_count are incremented.
  - No same-cycle bypass: a tag freed in cycle N is first visible as alloc_tag in cycle N+1 at the earliest.
- Free when retire_count == DEPTH:
  - The write is dropped.
  - overflow_err <= 1, held until reset.
- Commit:
  - commit_req advances retire_head and decrements retire_count.
  - A commit with retire_count == count already (nothing speculatively allocated) is illegal; the upstream ROB guarantees it never occurs.
- Simultaneous events in one cycle:
  - alloc+free: count unchanged; head and tail both advance.
  - commit+free: retire_count unchanged.
- Flush (behaviour with FREELIST_FLUSH_EN):
  - head <= retire_head plus the commit applied in the same cycle.
  - count <= retire_count after that cycle's free/commit.
  - Alloc in the flush cycle is suppressed.
  - Free and commit in the flush cycle are both applied.
- Count invariants:
  - count <= retire_count <= DEPTH.
  - free_count = count, registered.

Optional Feature:
- Macro: FREELIST_FLUSH_EN.
- With the macro defined:
  - retire_head and retire_count are implemented.
  - flush restores as described in Behaviour.
- Without the macro:
  - retire_head and retire_count logic is removed.
  - flush and commit_req are ignored.
  - Overflow check uses count instead of retire_count.
  - The core relies on full pipeline drain plus reset for recovery.

Test Plan:
- Reset check: release rst -> alloc_valid=1, alloc_tag=32, free_count=32, overflow_err=0.
- Drain: alloc_req held 32 cycles -> tags 32..63 in order; then alloc_valid=0, free_count=0; a 33rd request does not move head.
- Recycle: drain, then free_tag=5 at cycle N with alloc_req held -> alloc_valid=0 in cycle N, alloc_tag=5 and valid in N+1, consumed in N+1, free_count back to 0.
- Wrap and simultaneous: from full, alloc 3 (32,33,34), then alloc+free(7) in one cycle -> free_count stays 29; after 28 more allocs the next tag is 7.
- Overflow: from reset, free_req with tag 9 -> free_count stays 32, overflow_err=1 and stays 1; next alloc_tag still 32.
- Flush (FREELIST_FLUSH_EN): alloc 4 tags, commit 1, then flush asserted with alloc_req=1 -> alloc_tag=33 and free_count=31 next cycle; no tag consumed in the flush cycle.
